// File: rtl/cla_shift_add_mul.sv
// Sequential 32x32->64 shift-and-add multiplier driving a 64-bit carry look-ahead adder.
// Define CLA_MUL_SIGNED_EN for two's-complement operands (adds the NEG state).

module CLA_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum
);
    logic [63:0] g, p, c;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit look-ahead groups; the group carry is passed on to the next group.
    always_comb begin
        logic cg;
        c  = '0;
        cg = cin;
        for (int k = 0; k < 16; k++) begin
            c[4*k]   = cg;
            c[4*k+1] = g[4*k] | (p[4*k] & cg);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg);
            cg       = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | ((&p[4*k +: 4]) & cg);
        end
    end

    assign sum = p ^ c;
endmodule

module cla_shift_add_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product
);
`ifdef CLA_MUL_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_NEG} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplr_q, mplr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_mag, b_mag;
    logic [63:0] add_a, add_b, sum;
    logic        add_cin;

`ifdef CLA_MUL_SIGNED_EN
    logic neg_q, neg_d;

    // -2^31 negates to itself, which is the correct 32-bit unsigned magnitude.
    assign a_mag = a[31] ? (~a + 32'd1) : a;
    assign b_mag = b[31] ? (~b + 32'd1) : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    always_comb begin
        add_a   = acc_q;
        add_b   = mplr_q[0] ? mcand_q : 64'd0;
        add_cin = 1'b0;
`ifdef CLA_MUL_SIGNED_EN
        if (state_q == S_NEG) begin
            add_a   = ~acc_q;
            add_b   = 64'd0;
            add_cin = 1'b1;
        end
`endif
    end

    CLA_64bit u_cla (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (sum)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
`ifdef CLA_MUL_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            S_IDLE: if (in_valid) begin
                acc_d   = 64'd0;
                mcand_d = {32'd0, a_mag};
                mplr_d  = b_mag;
                cnt_d   = 5'd0;
`ifdef CLA_MUL_SIGNED_EN
                neg_d   = a[31] ^ b[31];
`endif
                state_d = S_BUSY;
            end
            S_BUSY: begin
                acc_d   = sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
`ifdef CLA_MUL_SIGNED_EN
                    state_d = neg_q ? S_NEG : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CLA_MUL_SIGNED_EN
            S_NEG: begin
                acc_d   = sum;
                state_d = S_DONE;
            end
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= 64'd0;
            mcand_q <= 64'd0;
            mplr_q  <= 32'd0;
            cnt_q   <= 5'd0;
`ifdef CLA_MUL_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
`ifdef CLA_MUL_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = acc_q;
endmodule

// File: tb/tb_cla_shift_add_mul.sv
// Bench for cla_shift_add_mul: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed products and latencies.

module tb_cla_shift_add_mul;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    cla_shift_add_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the product is plain multiplication, delivered a fixed number of
    // edges after acceptance (one extra for a negative signed result).
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
`ifdef CLA_MUL_SIGNED_EN
        return 64'(longint'($signed(x)) * longint'($signed(y)));
`else
        return {32'd0, x} * {32'd0, y};
`endif
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef CLA_MUL_SIGNED_EN
        return 32 + int'(x[31] ^ y[31]);
`else
        return 32 + 0 * int'(x[0] ^ y[0]);
`endif
    endfunction

    int          m_phase = 0;   // 0 waiting for operands, 1 computing, 2 result held
    int          m_timer = 0;
    logic [63:0] m_res   = '0;
    logic [63:0] m_prod  = '0;
    bit          m_ok    = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_timer <= 0;
            m_ok    <= 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   <= ref_mul(a, b);
                    m_timer <= ref_lat(a, b);
                    m_phase <= 1;
                end
                1: begin
                    m_timer <= m_timer - 1;
                    if (m_timer == 1) begin
                        m_phase <= 2;
                        m_prod  <= m_res;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_ok && rst_n) begin
            chk("model in_ready", 64'(in_ready), 64'(m_phase == 0));
            chk("model out_valid", 64'(out_valid), 64'(m_phase == 2));
            if (m_phase == 2) chk("model product", product, m_prod);
        end
    end

    // Accept x*y, optionally pulse a stray in_valid or reset at a given step,
    // then hold the result for 'hold' cycles before unloading.
    task automatic run(input string nm, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int exp_lat, input int hold,
                       input int pulse_at, input int rst_at);
        int n;
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (n == pulse_at) begin a = 32'd1; b = 32'd1; in_valid = 1'b1; end
            else in_valid = 1'b0;
            rst_n = (n == rst_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            n++;
            if (rst_at >= 0 && n > rst_at) break;
        end
        in_valid = 1'b0;
        if (rst_at >= 0) begin
            rst_n = 1'b1;
            chk({nm, " reset out_valid"}, 64'(out_valid), 64'd0);
            chk({nm, " reset product"}, product, 64'd0);
            chk({nm, " reset in_ready"}, 64'(in_ready), 64'd1);
            repeat (40) @(negedge clk);
            chk({nm, " no stale result"}, 64'(out_valid), 64'd0);
            return;
        end
        if (!out_valid) begin
            chk({nm, " timeout"}, 64'(out_valid), 64'd1);
            return;
        end
        chk({nm, " latency"}, 64'(n), 64'(exp_lat));
        chk({nm, " product"}, product, exp);
        chk({nm, " in_ready low"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " held product"}, product, exp);
            chk({nm, " held out_valid"}, 64'(out_valid), 64'd1);
            chk({nm, " held in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " back to idle"}, 64'(in_ready), 64'd1);
        chk({nm, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset product", product, 64'd0);

        // Latency counted in edges after the accept edge: result visible after E32.
        run("basic", 32'd3, 32'd5, 64'd15, 32, 0, -1, -1);
        run("zero", 32'd0, 32'd0, 64'd0, 32, 0, -1, -1);
`ifdef CLA_MUL_SIGNED_EN
        run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 32, 0, -1, -1);
        run("neg1x1", 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0, -1, -1);
        run("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32, 0, -1, -1);
        run("neg_zero", 32'hFFFF_FFFF, 32'd0, 64'd0, 33, 0, -1, -1);
`else
        run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 0, -1, -1);
        run("neg1x1", 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 32, 0, -1, -1);
        run("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32, 0, -1, -1);
`endif
        run("backpressure", 32'd7, 32'd9, 64'd63, 32, 10, -1, -1);
        run("ignored", 32'd6, 32'd7, 64'd42, 32, 0, 5, -1);
        repeat (40) @(negedge clk);
        chk("ignored single episode", 64'(out_valid), 64'd0);
        run("midreset", 32'h1234, 32'h5678, 64'd0, 32, 0, -1, 10);
        run("after reset", 32'd2, 32'd2, 64'd4, 32, 0, -1, -1);
        run("mixed", 32'd100000, 32'd300000, 64'd30000000000, 32, 2, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
